// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: data width,
// owned CSR addresses, trap cause codes and the controller state enum.
package trap_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    typedef enum logic [3:0] {
        CAUSE_INSN_MISALIGNED = 4'd0,
        CAUSE_ILLEGAL_INSN    = 4'd2,
        CAUSE_BREAKPOINT      = 4'd3,
        CAUSE_ECALL_M         = 4'd11
    } trap_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT
    } trap_state_e;

    function automatic logic csr_is_owned(input logic [11:0] addr);
        return (addr == CSR_MTVEC) || (addr == CSR_MEPC) ||
               (addr == CSR_MCAUSE) || (addr == CSR_MTVAL);
    endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// mtvec/mepc/mcause/mtval storage with write masking and the CSR read mux.
// A trap latch overrides a same-cycle CSR write to mepc/mcause/mtval.
module trap_csr_regs
    import trap_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic            csr_write_en,
    input  logic [XLEN-1:0] csr_write_data,
    input  logic            trap_latch,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [3:0]      trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic            csr_hit,
    output logic [XLEN-1:0] csr_read_data
);

    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec  <= RESET_MTVEC & MTVEC_MASK;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else begin
            if (csr_write_en && csr_addr == CSR_MTVEC)
                mtvec <= csr_write_data & MTVEC_MASK;
            if (trap_latch) begin
                mepc   <= trap_pc & MEPC_MASK;
                mcause <= {{(XLEN-4){1'b0}}, trap_cause};
                mtval  <= trap_tval;
            end else if (csr_write_en) begin
                case (csr_addr)
                    CSR_MEPC:   mepc   <= csr_write_data & MEPC_MASK;
                    CSR_MCAUSE: mcause <= csr_write_data;
                    CSR_MTVAL:  mtval  <= csr_write_data;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        csr_hit       = csr_is_owned(csr_addr);
        csr_read_data = '0;
        case (csr_addr)
            CSR_MTVEC:  csr_read_data = mtvec;
            CSR_MEPC:   csr_read_data = mepc;
            CSR_MCAUSE: csr_read_data = mcause;
            CSR_MTVAL:  csr_read_data = mtval;
            default:    csr_read_data = '0;
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: accepts exceptions/MRET, flushes and drains
// the pipeline, then issues a single fetch redirect.
//
//   state       | meaning
//   ST_IDLE     | ready for an exception or MRET request
//   ST_DRAIN    | flushing, waiting for pipeline_empty
//   ST_REDIRECT | one-cycle redirect pulse to the latched target
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    output logic            exc_ready,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            pipeline_empty,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target,
    input  logic [11:0]     csr_addr,
    input  logic            csr_write_en,
    input  logic [XLEN-1:0] csr_write_data,
    output logic            csr_hit,
    output logic [XLEN-1:0] csr_read_data
);

    trap_state_e     state, state_nxt;
    logic            accept_exc;
    logic            accept_mret;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;

    trap_csr_regs #(.RESET_MTVEC(RESET_MTVEC)) u_regs (
        .clk            (clk),
        .rst            (rst),
        .csr_addr       (csr_addr),
        .csr_write_en   (csr_write_en),
        .csr_write_data (csr_write_data),
        .trap_latch     (accept_exc),
        .trap_pc        (exc_pc),
        .trap_cause     (exc_cause),
        .trap_tval      (exc_tval),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .csr_hit        (csr_hit),
        .csr_read_data  (csr_read_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        exc_ready      = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        accept_exc     = 1'b0;
        accept_mret    = 1'b0;
        case (state)
            ST_IDLE: begin
                exc_ready = 1'b1;
                if (exc_valid) begin
                    accept_exc = 1'b1;
                    state_nxt  = ST_DRAIN;
                end else if (mret_valid) begin
                    accept_mret = 1'b1;
                    state_nxt   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                flush = 1'b1;
                if (pipeline_empty) state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Target is captured from pre-write mtvec/mepc so a same-cycle CSR write
    // cannot steer the trap being accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              target <= '0;
        else if (accept_exc)  target <= mtvec;
        else if (accept_mret) target <= mepc;
    end

    assign redirect_target = redirect_valid ? target : '0;

endmodule
